// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 signed max-pool: horizontal pair maxima from even rows are
// parked in a half-row line buffer and combined with the odd row as it streams in.
module max_pool_2x2 #(
  parameter int DATA_W = 24,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              dout_valid,
  output logic [DATA_W-1:0] dout,
  output logic              frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int NB = IMG_W / 2;
  localparam int HW = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] pair_reg;
  logic [DATA_W-1:0] line_buf [NB];
  logic [HW-1:0]     half_col;
  logic              last_col;
  logic              last_row;
  logic [DATA_W-1:0] hmax;
  logic [DATA_W-1:0] pool;

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  assign half_col = HW'(col >> 1);
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));
  assign hmax     = smax(pair_reg, din);
  assign pool     = smax(line_buf[half_col], hmax);

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      pair_reg   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
      if (din_valid) begin
        if (!col[0]) begin
          pair_reg <= din;
        end else if (row[0]) begin
          dout       <= pool;
          dout_valid <= 1'b1;
          frame_done <= last_row && last_col;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Even rows only write and odd rows only read, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (!rst && din_valid && col[0] && !row[0]) begin
      line_buf[half_col] <= hmax;
    end
  end

endmodule
